// File: rtl/vm_pkg.sv
// Shared definitions for the multi-product vending machine.
// Holds coin values, the controller state encoding and the greedy
// change-coin selector used while paying out change.
package vm_pkg;

  localparam int unsigned COIN_N = 5;
  localparam int unsigned COIN_I = 10;
  localparam int unsigned COIN_Q = 25;
  localparam int unsigned COIN_D = 100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } vm_state_e;

  // Largest change coin (25/10/5) not exceeding amount; 0 if none fits.
  function automatic int unsigned change_coin(input int unsigned amount);
    if (amount >= COIN_Q)      return COIN_Q;
    else if (amount >= COIN_I) return COIN_I;
    else if (amount >= COIN_N) return COIN_N;
    else                       return 0;
  endfunction

endpackage

// File: rtl/vm_stock_bank.sv
// Per-item stock counters for the vending machine.
// Ports:
//   clk, rst_n : clock and async active-low reset (reset loads STOCK_DEPTH)
//   load_all   : reload every counter to STOCK_DEPTH
//   dec        : one-hot decrement request
//   sold_out   : counter == 0, decoded straight from the registers
module vm_stock_bank #(
  parameter int unsigned NUM_ITEMS   = 3,
  parameter int unsigned STOCK_W     = 4,
  parameter int unsigned STOCK_DEPTH = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_all,
  input  logic [NUM_ITEMS-1:0] dec,
  output logic [NUM_ITEMS-1:0] sold_out
);

  logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0] stock_d [NUM_ITEMS];

  // Next count: reload wins; decrement never wraps below zero.
  always_comb begin
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      stock_d[i] = stock_q[i];
      if (load_all) begin
        stock_d[i] = STOCK_W'(STOCK_DEPTH);
      end else if (dec[i] && (stock_q[i] != '0)) begin
        stock_d[i] = stock_q[i] - STOCK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i] <= STOCK_W'(STOCK_DEPTH);
      end
    end else begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i] <= stock_d[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      sold_out[i] = (stock_q[i] == '0);
    end
  end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: coin collection into a saturating
// credit register, per-item priced vend, greedy one-coin-per-cycle change.
// Ports:
//   clk, R            : clock, async active-low reset
//   N, I, Q, D        : coin pulses (5, 10, 25, 100)
//   sel               : one-hot product select
//   cancel, restock   : refund request, reload all stock (IDLE only)
//   vend              : product release pulse
//   chg_n/chg_i/chg_q : change-coin pulses
//   coin_reject       : inserted coin returned
//   sel_err           : selection refused
//   sold_out          : per-item stock empty
//   credit, busy      : current credit, high in VEND/CHANGE
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int unsigned                   NUM_ITEMS   = 3,
  parameter int unsigned                   CREDIT_W    = 8,
  parameter int unsigned                   MAX_CREDIT  = 200,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_LIST  = {8'd70, 8'd70, 8'd70},
  parameter int unsigned                   STOCK_W     = 4,
  parameter int unsigned                   STOCK_DEPTH = 10
) (
  input  logic                 clk,
  input  logic                 R,
  input  logic                 N,
  input  logic                 I,
  input  logic                 Q,
  input  logic                 D,
  input  logic [NUM_ITEMS-1:0] sel,
  input  logic                 cancel,
  input  logic                 restock,
  output logic [NUM_ITEMS-1:0] vend,
  output logic                 chg_n,
  output logic                 chg_i,
  output logic                 chg_q,
  output logic                 coin_reject,
  output logic                 sel_err,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 busy
);

  localparam int unsigned SUM_W = CREDIT_W + 1;

  vm_state_e             state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [NUM_ITEMS-1:0]  vend_q, vend_d;
  logic                  chg_n_q, chg_n_d;
  logic                  chg_i_q, chg_i_d;
  logic                  chg_q_q, chg_q_d;
  logic                  coin_reject_q, coin_reject_d;
  logic                  sel_err_q, sel_err_d;
  logic                  busy_q, busy_d;

  logic [3:0]            coin_bits;
  logic                  coin_any;
  logic                  coin_valid;
  logic [CREDIT_W-1:0]   coin_val;
  logic [SUM_W-1:0]      coin_sum;
  logic                  coin_fits;
  logic [CREDIT_W-1:0]   sel_price;
  logic [CREDIT_W-1:0]   vend_price;
  logic                  sel_ok;
  logic                  stock_load;
  logic [NUM_ITEMS-1:0]  stock_dec;
  logic                  pay;
  logic [CREDIT_W-1:0]   pay_from;
  logic [CREDIT_W-1:0]   pay_coin;
  logic [CREDIT_W-1:0]   remainder;

  vm_stock_bank #(
    .NUM_ITEMS   (NUM_ITEMS),
    .STOCK_W     (STOCK_W),
    .STOCK_DEPTH (STOCK_DEPTH)
  ) u_stock (
    .clk      (clk),
    .rst_n    (R),
    .load_all (stock_load),
    .dec      (stock_dec),
    .sold_out (sold_out)
  );

  // Coin decode: only a single coin line counts as a valid coin.
  always_comb begin
    coin_bits  = {D, Q, I, N};
    coin_any   = |coin_bits;
    coin_valid = $onehot(coin_bits);
    unique case (coin_bits)
      4'b0001: coin_val = CREDIT_W'(COIN_N);
      4'b0010: coin_val = CREDIT_W'(COIN_I);
      4'b0100: coin_val = CREDIT_W'(COIN_Q);
      4'b1000: coin_val = CREDIT_W'(COIN_D);
      default: coin_val = '0;
    endcase
    coin_sum  = SUM_W'(credit_q) + SUM_W'(coin_val);
    coin_fits = coin_valid && (coin_sum <= SUM_W'(MAX_CREDIT));
  end

  // Price lookup for the live selection and for the item being vended.
  always_comb begin
    sel_price  = '0;
    vend_price = '0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      if (sel[i])    sel_price  = sel_price  | PRICE_LIST[i*CREDIT_W +: CREDIT_W];
      if (vend_q[i]) vend_price = vend_price | PRICE_LIST[i*CREDIT_W +: CREDIT_W];
    end
    sel_ok = $onehot(sel) && (|(sel & ~sold_out)) && (credit_q >= sel_price);
  end

  // Next-state, credit and pulse-output logic.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    vend_d        = '0;
    chg_n_d       = 1'b0;
    chg_i_d       = 1'b0;
    chg_q_d       = 1'b0;
    coin_reject_d = 1'b0;
    sel_err_d     = 1'b0;
    stock_load    = 1'b0;
    stock_dec     = '0;
    pay           = 1'b0;
    pay_from      = '0;
    pay_coin      = '0;
    remainder     = credit_q - vend_price;

    unique case (state_q)
      IDLE: begin
        if (coin_any) begin
          if (coin_fits) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = COLLECT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
        stock_load = restock;
      end

      COLLECT: begin
        if (cancel) begin
          coin_reject_d = coin_any;
          if (credit_q == '0) begin
            state_d = IDLE;
          end else begin
            pay      = 1'b1;
            pay_from = credit_q;
          end
        end else if ((sel != '0) && sel_ok) begin
          vend_d        = sel;
          state_d       = VEND;
          coin_reject_d = coin_any;
        end else begin
          sel_err_d = (sel != '0);
          if (coin_any) begin
            if (coin_fits) credit_d = coin_sum[CREDIT_W-1:0];
            else           coin_reject_d = 1'b1;
          end
        end
      end

      VEND: begin
        coin_reject_d = coin_any;
        sel_err_d     = |sel;
        stock_dec     = vend_q;
        if (remainder == '0) begin
          credit_d = '0;
          state_d  = IDLE;
        end else begin
          pay      = 1'b1;
          pay_from = remainder;
        end
      end

      CHANGE: begin
        coin_reject_d = coin_any;
        sel_err_d     = |sel;
        if (credit_q == '0) begin
          state_d = IDLE;
        end else begin
          pay      = 1'b1;
          pay_from = credit_q;
        end
      end

      default: state_d = IDLE;
    endcase

    // The coin pulsed this edge is already deducted from the shown credit.
    if (pay) begin
      pay_coin = CREDIT_W'(change_coin(32'(pay_from)));
      credit_d = pay_from - pay_coin;
      state_d  = CHANGE;
      chg_q_d  = (pay_coin == CREDIT_W'(COIN_Q));
      chg_i_d  = (pay_coin == CREDIT_W'(COIN_I));
      chg_n_d  = (pay_coin == CREDIT_W'(COIN_N));
    end

    busy_d = (state_d == VEND) || (state_d == CHANGE);
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      vend_q        <= '0;
      chg_n_q       <= 1'b0;
      chg_i_q       <= 1'b0;
      chg_q_q       <= 1'b0;
      coin_reject_q <= 1'b0;
      sel_err_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      vend_q        <= vend_d;
      chg_n_q       <= chg_n_d;
      chg_i_q       <= chg_i_d;
      chg_q_q       <= chg_q_d;
      coin_reject_q <= coin_reject_d;
      sel_err_q     <= sel_err_d;
      busy_q        <= busy_d;
    end
  end

  assign vend        = vend_q;
  assign chg_n       = chg_n_q;
  assign chg_i       = chg_i_q;
  assign chg_q       = chg_q_q;
  assign coin_reject = coin_reject_q;
  assign sel_err     = sel_err_q;
  assign credit      = credit_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Self-checking bench for vending_machine_multi: directed vector table,
// hand-written multi-cycle sequences and a randomized run against a
// queue-based behavioural model.
module tb_vending_machine_multi;

  localparam logic [3:0] CN = 4'b0001;
  localparam logic [3:0] CI = 4'b0010;
  localparam logic [3:0] CQ = 4'b0100;
  localparam logic [3:0] CD = 4'b1000;
  localparam logic [2:0] GQ = 3'b100;
  localparam logic [2:0] GI = 3'b010;
  localparam logic [2:0] GN = 3'b001;
  localparam int MAXC  = 200;
  localparam int DEPTH = 10;

  logic       clk, R, N, I, Q, D, cancel, restock;
  logic [2:0] sel, vend, sold_out;
  logic       chg_n, chg_i, chg_q, coin_reject, sel_err, busy;
  logic [7:0] credit;

  int total = 0;
  int bad   = 0;

  vending_machine_multi dut (
    .clk(clk), .R(R), .N(N), .I(I), .Q(Q), .D(D),
    .sel(sel), .cancel(cancel), .restock(restock),
    .vend(vend), .chg_n(chg_n), .chg_i(chg_i), .chg_q(chg_q),
    .coin_reject(coin_reject), .sel_err(sel_err), .sold_out(sold_out),
    .credit(credit), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] coin;
    logic [2:0] sel;
    logic       cancel;
    logic [2:0] vend;
    logic [2:0] chg;
    logic       rej;
    logic       err;
    int         credit;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [2:0] vend;
    logic [2:0] chg;
    logic [2:0] sold;
    logic       rej;
    logic       err;
    logic       busy;
    int         credit;
  } exp_t;

  vec_t tbl[$];

  // ---------------- behavioural model ----------------
  int m_credit;
  int m_stock[3];
  int m_vend_item;
  bit m_in_change;
  int m_q[$];
  int price[3] = '{70, 70, 70};

  function automatic vec_t mk(logic [3:0] c, logic [2:0] s, logic cn,
                              logic [2:0] v, logic [2:0] g, logic rj,
                              logic er, int cr, logic b);
    vec_t t;
    t.coin = c; t.sel = s; t.cancel = cn; t.vend = v; t.chg = g;
    t.rej = rj; t.err = er; t.credit = cr; t.busy = b;
    return t;
  endfunction

  function automatic int coin_value(logic [3:0] c);
    case (c)
      4'b0001: return 5;
      4'b0010: return 10;
      4'b0100: return 25;
      4'b1000: return 100;
      default: return 0;
    endcase
  endfunction

  function automatic void model_reset();
    m_credit = 0;
    for (int k = 0; k < 3; k++) m_stock[k] = DEPTH;
    m_vend_item = -1;
    m_in_change = 1'b0;
    m_q.delete();
  endfunction

  // Greedy change as a list of coins derived from the amount.
  function automatic void fill_change(int amt);
    m_q.delete();
    for (int k = 0; k < amt / 25; k++) m_q.push_back(25);
    for (int k = 0; k < (amt % 25) / 10; k++) m_q.push_back(10);
    for (int k = 0; k < ((amt % 25) % 10) / 5; k++) m_q.push_back(5);
  endfunction

  function automatic bit try_add(logic [3:0] c);
    int cv;
    cv = coin_value(c);
    if (c == 4'b0) return 1'b0;
    if (cv != 0 && m_credit + cv <= MAXC) begin
      m_credit += cv;
      return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic exp_t model_step(logic [3:0] c, logic [2:0] s, logic cn, logic rs);
    exp_t e;
    int   idx, c0, r;
    bit   take;
    e.vend = '0; e.chg = '0; e.rej = 1'b0; e.err = 1'b0;
    take = 1'b0;
    if (m_vend_item >= 0) begin
      e.rej = |c; e.err = |s;
      r = m_credit - price[m_vend_item];
      m_stock[m_vend_item]--;
      m_vend_item = -1;
      m_credit = r;
      fill_change(r);
      take = 1'b1;
    end else if (m_in_change) begin
      e.rej = |c; e.err = |s;
      take = 1'b1;
    end else if (m_credit == 0) begin
      if (c != 4'b0) begin
        if (coin_value(c) != 0) m_credit = coin_value(c);
        else e.rej = 1'b1;
      end
      if (rs) for (int k = 0; k < 3; k++) m_stock[k] = DEPTH;
    end else if (cn) begin
      e.rej = |c;
      fill_change(m_credit);
      take = 1'b1;
    end else if (s != 3'b0) begin
      idx = (s == 3'b001) ? 0 : (s == 3'b010) ? 1 : (s == 3'b100) ? 2 : -1;
      if (idx >= 0 && m_stock[idx] > 0 && m_credit >= price[idx]) begin
        m_vend_item = idx;
        e.vend = s;
        e.rej = |c;
      end else begin
        e.err = 1'b1;
        e.rej = try_add(c);
      end
    end else begin
      e.rej = try_add(c);
    end
    if (take) begin
      if (m_q.size() == 0) begin
        m_in_change = 1'b0;
      end else begin
        c0 = m_q.pop_front();
        m_credit -= c0;
        e.chg = (c0 == 25) ? GQ : (c0 == 10) ? GI : GN;
        m_in_change = 1'b1;
      end
    end
    e.credit = m_credit;
    e.busy   = (m_vend_item >= 0) || m_in_change;
    for (int k = 0; k < 3; k++) e.sold[k] = (m_stock[k] == 0);
    return e;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [2:0] v, input logic [2:0] g,
                         input logic rj, input logic er, input int cr, input logic b);
    chk({nm, " vend"}, 32'(vend), 32'(v));
    chk({nm, " chg"}, 32'({chg_q, chg_i, chg_n}), 32'(g));
    chk({nm, " coin_reject"}, 32'(coin_reject), 32'(rj));
    chk({nm, " sel_err"}, 32'(sel_err), 32'(er));
    chk({nm, " credit"}, 32'(credit), 32'(cr));
    chk({nm, " busy"}, 32'(busy), 32'(b));
  endtask

  task automatic set_in(input logic [3:0] c, input logic [2:0] s, input logic cn, input logic rs);
    {D, Q, I, N} = c;
    sel = s;
    cancel = cn;
    restock = rs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [3:0] c);
    set_in(c, 3'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic feed70();
    feed(CQ); feed(CQ); feed(CI); feed(CI);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    set_in(4'b0, 3'b0, 1'b0, 1'b0);
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({nm, " idle"}, 32'(busy), 32'(0));
  endtask

  // ---------------- test ----------------
  initial begin
    exp_t e;
    logic [3:0] rc;
    logic [2:0] rs_sel;
    logic rcn, rrs;
    int p;

    R = 1'b0;
    set_in(4'b0, 3'b0, 1'b0, 1'b0);
    tick();
    chk_all("reset", 3'b0, 3'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("reset sold_out", 32'(sold_out), 32'(0));
    R = 1'b1;
    tick();

    // Q,Q,D then item 0: change 80
    tbl.push_back(mk(CQ, 3'b000, 0, 3'b000, 3'b0, 0, 0, 25, 0));
    tbl.push_back(mk(CQ, 3'b000, 0, 3'b000, 3'b0, 0, 0, 50, 0));
    tbl.push_back(mk(CD, 3'b000, 0, 3'b000, 3'b0, 0, 0, 150, 0));
    tbl.push_back(mk(4'b0, 3'b001, 0, 3'b001, 3'b0, 0, 0, 150, 1));
    tbl.push_back(mk(4'b0, 3'b000, 0, 3'b000, GQ, 0, 0, 55, 1));
    tbl.push_back(mk(4'b0, 3'b000, 0, 3'b000, GQ, 0, 0, 30, 1));
    tbl.push_back(mk(4'b0, 3'b000, 0, 3'b000, GQ, 0, 0, 5, 1));
    tbl.push_back(mk(4'b0, 3'b000, 0, 3'b000, GN, 0, 0, 0, 1));
    tbl.push_back(mk(4'b0, 3'b000, 0, 3'b000, 3'b0, 0, 0, 0, 0));
    // N,I,Q = 40, short select, D, item 1: change 70
    tbl.push_back(mk(CN, 3'b000, 0, 3'b000, 3'b0, 0, 0, 5, 0));
    tbl.push_back(mk(CI, 3'b000, 0, 3'b000, 3'b0, 0, 0, 15, 0));
    tbl.push_back(mk(CQ, 3'b000, 0, 3'b000, 3'b0, 0, 0, 40, 0));
    tbl.push_back(mk(4'b0, 3'b010, 0, 3'b000, 3'b0, 0, 1, 40, 0));
    tbl.push_back(mk(CD, 3'b000, 0, 3'b000, 3'b0, 0, 0, 140, 0));
    tbl.push_back(mk(4'b0, 3'b010, 0, 3'b010, 3'b0, 0, 0, 140, 1));
    tbl.push_back(mk(4'b0, 3'b000, 0, 3'b000, GQ, 0, 0, 45, 1));
    tbl.push_back(mk(4'b0, 3'b000, 0, 3'b000, GQ, 0, 0, 20, 1));
    tbl.push_back(mk(4'b0, 3'b000, 0, 3'b000, GI, 0, 0, 10, 1));
    tbl.push_back(mk(4'b0, 3'b000, 0, 3'b000, GI, 0, 0, 0, 1));
    tbl.push_back(mk(4'b0, 3'b000, 0, 3'b000, 3'b0, 0, 0, 0, 0));
    // non-one-hot select, double coin, cancel 100
    tbl.push_back(mk(CD, 3'b000, 0, 3'b000, 3'b0, 0, 0, 100, 0));
    tbl.push_back(mk(4'b0, 3'b011, 0, 3'b000, 3'b0, 0, 1, 100, 0));
    tbl.push_back(mk(CN | CI, 3'b000, 0, 3'b000, 3'b0, 1, 0, 100, 0));
    tbl.push_back(mk(4'b0, 3'b000, 1, 3'b000, GQ, 0, 0, 75, 1));
    tbl.push_back(mk(4'b0, 3'b000, 0, 3'b000, GQ, 0, 0, 50, 1));
    tbl.push_back(mk(4'b0, 3'b000, 0, 3'b000, GQ, 0, 0, 25, 1));
    tbl.push_back(mk(4'b0, 3'b000, 0, 3'b000, GQ, 0, 0, 0, 1));
    tbl.push_back(mk(4'b0, 3'b000, 0, 3'b000, 3'b0, 0, 0, 0, 0));

    for (int k = 0; k < tbl.size(); k++) begin
      set_in(tbl[k].coin, tbl[k].sel, tbl[k].cancel, 1'b0);
      tick();
      chk_all($sformatf("row%0d", k), tbl[k].vend, tbl[k].chg, tbl[k].rej,
              tbl[k].err, tbl[k].credit, tbl[k].busy);
    end

    // Saturation at 200, then cancel into eight quarters
    feed(CD);
    feed(CD);
    chk_all("sat 200", 3'b0, 3'b0, 1'b0, 1'b0, 200, 1'b0);
    feed(CQ);
    chk_all("sat over", 3'b0, 3'b0, 1'b1, 1'b0, 200, 1'b0);
    set_in(4'b0, 3'b0, 1'b1, 1'b0);
    tick();
    chk_all("cancel q1", 3'b0, GQ, 1'b0, 1'b0, 175, 1'b1);
    for (int j = 1; j < 8; j++) begin
      if (j == 3) set_in(CN, 3'b001, 1'b0, 1'b0);
      else        set_in(4'b0, 3'b0, 1'b0, 1'b0);
      tick();
      chk_all($sformatf("cancel q%0d", j + 1), 3'b0, GQ, j == 3, j == 3, 175 - 25 * j, 1'b1);
    end
    set_in(4'b0, 3'b0, 1'b0, 1'b0);
    tick();
    chk_all("cancel end", 3'b0, 3'b0, 1'b0, 1'b0, 0, 1'b0);

    // Drain item 2 with exact payment
    for (int k = 0; k < 10; k++) begin
      feed70();
      set_in(4'b0, 3'b100, 1'b0, 1'b0);
      tick();
      chk_all($sformatf("drain%0d vend", k), 3'b100, 3'b0, 1'b0, 1'b0, 70, 1'b1);
      set_in(4'b0, 3'b0, 1'b0, 1'b0);
      tick();
      chk_all($sformatf("drain%0d after", k), 3'b0, 3'b0, 1'b0, 1'b0, 0, 1'b0);
    end
    chk("sold_out item2", 32'(sold_out), 32'(3'b100));
    feed70();
    set_in(4'b0, 3'b100, 1'b0, 1'b0);
    tick();
    chk_all("sold sel", 3'b0, 3'b0, 1'b0, 1'b1, 70, 1'b0);
    set_in(4'b0, 3'b0, 1'b0, 1'b1);
    tick();
    chk("restock in collect", 32'(sold_out), 32'(3'b100));
    set_in(4'b0, 3'b0, 1'b1, 1'b0);
    tick();
    chk_all("sold cancel", 3'b0, GQ, 1'b0, 1'b0, 45, 1'b1);
    wait_idle("sold cancel");
    set_in(4'b0, 3'b0, 1'b0, 1'b1);
    tick();
    chk("restock idle", 32'(sold_out), 32'(0));
    set_in(4'b0, 3'b0, 1'b0, 1'b0);

    // Credit 95, item 0, reset during change
    feed(CQ); feed(CQ); feed(CQ); feed(CI); feed(CI);
    chk("credit 95", 32'(credit), 32'(95));
    set_in(4'b0, 3'b001, 1'b0, 1'b0);
    tick();
    set_in(4'b0, 3'b0, 1'b0, 1'b0);
    tick();
    chk_all("pre reset chg", 3'b0, GQ, 1'b0, 1'b0, 0, 1'b1);
    #2;
    R = 1'b0;
    #1;
    chk_all("mid reset", 3'b0, 3'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("mid reset sold_out", 32'(sold_out), 32'(0));
    @(posedge clk);
    #1;
    R = 1'b1;
    tick();
    chk_all("post reset", 3'b0, 3'b0, 1'b0, 1'b0, 0, 1'b0);

    // Randomized run against the model
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      p = $urandom_range(0, 99);
      if (p < 40)      rc = 4'(1 << $urandom_range(0, 3));
      else if (p < 45) rc = 4'(3 << $urandom_range(0, 2));
      else             rc = 4'b0;
      p = $urandom_range(0, 99);
      if (p < 15)      rs_sel = 3'(1 << $urandom_range(0, 2));
      else if (p < 18) rs_sel = 3'($urandom_range(3, 7));
      else             rs_sel = 3'b0;
      rcn = ($urandom_range(0, 99) < 4);
      rrs = ($urandom_range(0, 99) < 3);
      e = model_step(rc, rs_sel, rcn, rrs);
      set_in(rc, rs_sel, rcn, rrs);
      tick();
      chk_all($sformatf("rand%0d", cyc), e.vend, e.chg, e.rej, e.err, e.credit, e.busy);
      chk($sformatf("rand%0d sold_out", cyc), 32'(sold_out), 32'(e.sold));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
